// File: rtl/rv32i_writeback_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered
// write stage and a per-register busy scoreboard that drives the decode RAW/WAW stall.
module rv32i_writeback_arbiter #(
    parameter int NUM_SRC_P    = 3,
    parameter int XLEN_P       = 32,
    parameter int DEPTH_P      = 32,
    parameter int ADDR_WIDTH_P = $clog2(DEPTH_P)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_SRC_P-1:0]             src_valid_i,
    output logic [NUM_SRC_P-1:0]             src_ready_o,
    input  logic [NUM_SRC_P*ADDR_WIDTH_P-1:0] src_rd_addr_i,
    input  logic [NUM_SRC_P*XLEN_P-1:0]      src_wdata_i,
    input  logic                             issue_valid_i,
    input  logic [ADDR_WIDTH_P-1:0]          issue_rd_i,
    input  logic [ADDR_WIDTH_P-1:0]          rs1_addr_i,
    input  logic [ADDR_WIDTH_P-1:0]          rs2_addr_i,
    output logic                             stall_o,
    output logic                             rd_we_o,
    output logic [ADDR_WIDTH_P-1:0]          rd_addr_o,
    output logic [XLEN_P-1:0]                rd_wdata_o,
    output logic [DEPTH_P-1:0]               busy_o
);

    localparam int PTR_W = (NUM_SRC_P > 1) ? $clog2(NUM_SRC_P) : 1;

    // Handshake: a result moves when src_valid_i[i] & src_ready_o[i]; the producer
    // keeps valid/addr/data stable until then, and the write port never back-pressures.
    logic [PTR_W-1:0]        ptr_q;
    logic [NUM_SRC_P-1:0]    grant;
    logic [PTR_W-1:0]        grant_idx;
    logic                    found;
    int                      idx;
    logic                    xfer;
    logic [ADDR_WIDTH_P-1:0] sel_addr;
    logic [XLEN_P-1:0]       sel_data;
    logic [DEPTH_P-1:0]      busy_q;
    logic [DEPTH_P-1:0]      busy_d;
    logic                    hz_rs1;
    logic                    hz_rs2;
    logic                    hz_rd;

    function automatic logic in_range(input logic [ADDR_WIDTH_P-1:0] a);
        return int'(a) < DEPTH_P;
    endfunction

    // A pending register stops hazarding in the cycle its write lands (regfile bypass).
    function automatic logic hz(input logic [ADDR_WIDTH_P-1:0] r,
                                input logic [DEPTH_P-1:0]      busy,
                                input logic                    we,
                                input logic [ADDR_WIDTH_P-1:0] waddr);
        return (r != '0) && in_range(r) && busy[r] && !(we && (waddr == r));
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_SRC_P; k++) begin
            idx = (int'(ptr_q) + k) % NUM_SRC_P;
            if (!found && src_valid_i[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                found      = 1'b1;
            end
        end
    end

    assign xfer        = found;
    assign src_ready_o = grant;
    assign sel_addr    = src_rd_addr_i[int'(grant_idx)*ADDR_WIDTH_P +: ADDR_WIDTH_P];
    assign sel_data    = src_wdata_i[int'(grant_idx)*XLEN_P +: XLEN_P];

    assign hz_rs1  = hz(rs1_addr_i, busy_q, rd_we_o, rd_addr_o);
    assign hz_rs2  = hz(rs2_addr_i, busy_q, rd_we_o, rd_addr_o);
    assign hz_rd   = hz(issue_rd_i, busy_q, rd_we_o, rd_addr_o);
    assign stall_o = hz_rs1 | hz_rs2 | (issue_valid_i & hz_rd);
    assign busy_o  = busy_q;

    // Set is applied after clear so a newly issued producer keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (rd_we_o && in_range(rd_addr_o)) begin
            busy_d[rd_addr_o] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0) && in_range(issue_rd_i) && !stall_o) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_we_o    <= 1'b0;
            rd_addr_o  <= '0;
            rd_wdata_o <= '0;
            busy_q     <= '0;
            ptr_q      <= PTR_W'(NUM_SRC_P - 1);
        end else begin
            busy_q  <= busy_d;
            rd_we_o <= xfer && (sel_addr != '0) && in_range(sel_addr);
            if (xfer) begin
                rd_addr_o  <= sel_addr;
                rd_wdata_o <= sel_data;
                ptr_q      <= grant_idx;
            end
        end
    end

    a_issue_while_stalled : assert property (@(posedge clk_i) disable iff (rst_i)
        !(issue_valid_i && stall_o));

    a_untracked_writeback : assert property (@(posedge clk_i) disable iff (rst_i)
        !(xfer && (sel_addr != '0) && in_range(sel_addr) && !busy_q[sel_addr]));

endmodule

// File: tb/tb_rv32i_writeback_arbiter.sv
// Bench for rv32i_writeback_arbiter: per-source job queues drive producers, a
// reference model predicts grants/busy/stall and a queue holds expected writes.
module tb_rv32i_writeback_arbiter;

    localparam int N = 3;
    localparam int A = 5;
    localparam int X = 32;
    localparam int W = A + X;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [N-1:0]     src_valid_i = '0;
    logic [N-1:0]     src_ready_o;
    logic [N*A-1:0]   src_rd_addr_i = '0;
    logic [N*X-1:0]   src_wdata_i = '0;
    logic             issue_valid_i = 1'b0;
    logic [A-1:0]     issue_rd_i = '0;
    logic [A-1:0]     rs1_addr_i = '0;
    logic [A-1:0]     rs2_addr_i = '0;
    logic             stall_o;
    logic             rd_we_o;
    logic [A-1:0]     rd_addr_o;
    logic [X-1:0]     rd_wdata_o;
    logic [31:0]      busy_o;

    logic [W-1:0] job_q [0:N-1][$];
    logic [W-1:0] exp_q[$];
    logic [31:0]  m_busy = '0;
    int           m_ptr = N - 1;
    logic         m_we = 1'b0;
    logic [A-1:0] m_addr = '0;
    int           checks = 0;
    int           failures = 0;

    rv32i_writeback_arbiter #(
        .NUM_SRC_P(N), .XLEN_P(X), .DEPTH_P(32), .ADDR_WIDTH_P(A)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
        .src_rd_addr_i(src_rd_addr_i), .src_wdata_i(src_wdata_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .stall_o(stall_o), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
        .rd_wdata_o(rd_wdata_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic hz_m(input logic [A-1:0] r);
        return (r != 0) && m_busy[r] && !(m_we && (m_addr == r));
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            if (job_q[i].size() > 0) begin
                src_valid_i[i]          = 1'b1;
                src_rd_addr_i[i*A +: A] = job_q[i][0][W-1:X];
                src_wdata_i[i*X +: X]   = job_q[i][0][X-1:0];
            end else begin
                src_valid_i[i] = 1'b0;
            end
        end
    endtask

    task automatic push_job(input int src, input logic [A-1:0] rd, input logic [X-1:0] data);
        job_q[src].push_back({rd, data});
    endtask

    // One clock: model compare of combinational outputs at negedge, write-port check after posedge.
    task automatic cycle();
        logic         exp_stall;
        logic [N-1:0] exp_gnt;
        int           g;
        int           idx;
        logic [W-1:0] e;
        drive_src();
        @(negedge clk_i);
        if (!rst_i) begin
            exp_stall = hz_m(rs1_addr_i) | hz_m(rs2_addr_i) | (issue_valid_i & hz_m(issue_rd_i));
            checks++;
            if (stall_o !== exp_stall) begin
                failures++;
                $display("FAIL model_stall got=%b exp=%b t=%0t", stall_o, exp_stall, $time);
            end
            checks++;
            if (busy_o !== m_busy) begin
                failures++;
                $display("FAIL model_busy got=%h exp=%h t=%0t", busy_o, m_busy, $time);
            end
            exp_gnt = '0;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && job_q[idx].size() > 0) g = idx;
            end
            if (g >= 0) exp_gnt[g] = 1'b1;
            checks++;
            if (src_ready_o !== exp_gnt) begin
                failures++;
                $display("FAIL model_grant got=%b exp=%b t=%0t", src_ready_o, exp_gnt, $time);
            end
            if (m_we) m_busy[m_addr] = 1'b0;
            if (issue_valid_i && issue_rd_i != 0 && !exp_stall) m_busy[issue_rd_i] = 1'b1;
            m_we = 1'b0;
            if (g >= 0) begin
                e      = job_q[g].pop_front();
                m_ptr  = g;
                m_addr = e[W-1:X];
                if (e[W-1:X] != 0) begin
                    m_we = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end else begin
            m_busy = '0;
            m_ptr  = N - 1;
            m_we   = 1'b0;
            exp_q.delete();
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_we_o !== 1'b1 || rd_addr_o !== e[W-1:X] || rd_wdata_o !== e[X-1:0]) begin
                failures++;
                $display("FAIL write_port got=%b/%0d/%h exp=1/%0d/%h t=%0t",
                         rd_we_o, rd_addr_o, rd_wdata_o, e[W-1:X], e[X-1:0], $time);
            end
        end else if (rd_we_o !== 1'b0) begin
            failures++;
            $display("FAIL write_idle got=%b exp=0 t=%0t", rd_we_o, $time);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) push_job(i, 5'd0, $urandom);
        rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if (rd_we_o !== 1'b0 || busy_o !== 32'h0 || stall_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_state got we=%b busy=%h stall=%b exp 0/0/0",
                         rd_we_o, busy_o, stall_o);
            end
        end
        rst_i = 1'b0;
        drive_src();
        #1;
        checks++;
        if (src_ready_o !== 3'b001) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=001", src_ready_o);
        end
        repeat (4) cycle();
    endtask

    task automatic test_single_write();
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd5;
        cycle();
        issue_valid_i = 1'b0;
        push_job(1, 5'd5, 32'hDEADBEEF);
        drive_src();
        #1;
        checks++;
        if (src_ready_o !== 3'b010) begin
            failures++;
            $display("FAIL single_ready got=%b exp=010", src_ready_o);
        end
        cycle();
        checks++;
        if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_wdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", rd_we_o, rd_addr_o, rd_wdata_o);
        end
        cycle();
        checks++;
        if (busy_o[5] !== 1'b0) begin
            failures++;
            $display("FAIL single_clear got=%b exp=0", busy_o[5]);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_order [4];
        int           writes;
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            issue_valid_i = 1'b1;
            issue_rd_i    = A'(r);
            cycle();
        end
        issue_valid_i = 1'b0;
        push_job(0, 5'd1, $urandom);
        push_job(1, 5'd2, $urandom);
        push_job(2, 5'd3, $urandom);
        push_job(0, 5'd4, $urandom);
        writes = 0;
        for (int c = 0; c < 4; c++) begin
            drive_src();
            #1;
            checks++;
            if (src_ready_o !== exp_order[c]) begin
                failures++;
                $display("FAIL rr_grant%0d got=%b exp=%b", c, src_ready_o, exp_order[c]);
            end
            cycle();
            if (rd_we_o === 1'b1) writes++;
        end
        cycle();
        if (rd_we_o === 1'b1) writes++;
        checks++;
        if (writes != 4) begin
            failures++;
            $display("FAIL rr_writes got=%0d exp=4", writes);
        end
    endtask

    task automatic test_raw();
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd7;
        cycle();
        issue_valid_i = 1'b0;
        rs1_addr_i    = 5'd0;
        rs2_addr_i    = 5'd0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL raw_rs_zero got=%b exp=0", stall_o);
        end
        rs1_addr_i = 5'd7;
        repeat (3) cycle();
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL raw_stall got=%b exp=1", stall_o);
        end
        push_job(2, 5'd7, $urandom);
        cycle();
        checks++;
        if (stall_o !== 1'b0 || rd_we_o !== 1'b1 || rd_addr_o !== 5'd7) begin
            failures++;
            $display("FAIL raw_bypass got stall=%b we=%b addr=%0d exp 0/1/7", stall_o, rd_we_o, rd_addr_o);
        end
        repeat (2) cycle();
        rs1_addr_i = 5'd0;
    endtask

    task automatic test_collision();
        logic [X-1:0] d;
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd9;
        cycle();
        issue_valid_i = 1'b0;
        d = X'($urandom_range(1, 32'hFFFF));
        push_job(0, 5'd9, d);
        cycle();
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd9;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL coll_no_stall got=%b exp=0", stall_o);
        end
        cycle();
        issue_valid_i = 1'b0;
        checks++;
        if (busy_o[9] !== 1'b1) begin
            failures++;
            $display("FAIL coll_set_wins got=%b exp=1", busy_o[9]);
        end
        issue_valid_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL coll_waw got=%b exp=1", stall_o);
        end
        issue_valid_i = 1'b0;
        #1;
        push_job(0, 5'd9, $urandom);
        repeat (3) cycle();
    endtask

    task automatic test_x0_reset();
        push_job(0, 5'd0, $urandom);
        drive_src();
        #1;
        checks++;
        if (src_ready_o !== 3'b001) begin
            failures++;
            $display("FAIL x0_ready got=%b exp=001", src_ready_o);
        end
        cycle();
        checks++;
        if (rd_we_o !== 1'b0 || busy_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL x0_nowrite got we=%b busy0=%b exp 0/0", rd_we_o, busy_o[0]);
        end
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd12;
        cycle();
        issue_valid_i = 1'b0;
        push_job(1, 5'd12, $urandom);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        for (int i = 0; i < N; i++) job_q[i].delete();
        checks++;
        if (rd_we_o !== 1'b0 || busy_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_drop got we=%b busy=%h exp 0/0", rd_we_o, busy_o);
        end
        repeat (2) cycle();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_raw();
        test_collision();
        test_x0_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
